// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_detect_pkg;

    localparam int PAT_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_window.sv
// Serial shift window, saturating fill counter and length-masked pattern compare.
module seq_window
    import seq_detect_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               x,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               filled,
    output logic               hit
);

    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] window_next;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;

    // Compare uses the post-shift window so the completing bit counts.
    always_comb begin
        window_next = (window << 1) | {{(PAT_MAX-1){1'b0}}, x};
        fill_next   = (fill == LEN_W'(PAT_MAX)) ? fill : fill + LEN_W'(1);
        mask        = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        filled = shift && (fill_next >= len);
        hit    = filled && (((window_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
            fill   <= '0;
        end else if (clear) begin
            window <= '0;
            fill   <= '0;
        end else if (shift) begin
            window <= window_next;
            fill   <= fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: config registers, FSM, match counter.
// Define SEQ_DETECT_OVERLAP_EN to let matches overlap (window kept after a match).
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    input  logic               stop,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);
`ifdef SEQ_DETECT_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    state_t             state, state_next;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q, len_clamp;
    logic [CNT_W-1:0]   thresh_q, cnt_next;
    logic               latch, win_clear, shift, take, cnt_clear;
    logic               filled, hit;

    seq_window #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W)) u_window (
        .clk     (clk),
        .rst     (rst),
        .clear   (win_clear),
        .shift   (shift),
        .x       (x),
        .pattern (pat_q),
        .len     (len_q),
        .filled  (filled),
        .hit     (hit)
    );

    always_comb begin
        if (cfg_len == 4'd0)
            len_clamp = LEN_W'(1);
        else if (int'(cfg_len) > PAT_MAX)
            len_clamp = LEN_W'(PAT_MAX);
        else
            len_clamp = LEN_W'(cfg_len);
    end

    assign cfg_ready = (state == IDLE);
    assign latch     = cfg_valid && cfg_ready;
    assign busy      = (state == FILL) || (state == RUN);
    assign done      = (state == DONE);
    assign cnt_next  = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

    // stop masks shifting, so a coincident match never reaches z or the counter.
    always_comb begin
        state_next = state;
        win_clear  = 1'b0;
        shift      = 1'b0;
        take       = 1'b0;
        cnt_clear  = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = FILL;
                        win_clear  = 1'b1;
                        cnt_clear  = 1'b1;
                    end
                end
                FILL, RUN: begin
                    shift = x_valid;
                    if (hit) begin
                        take = 1'b1;
                        if ((thresh_q != '0) && (cnt_next == thresh_q)) begin
                            state_next = DONE;
                        end else if (!OVERLAP) begin
                            state_next = FILL;
                            win_clear  = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end else if (filled) begin
                        state_next = RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= LEN_W'(1);
            thresh_q  <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
        end else begin
            state <= state_next;
            z     <= take;
            if (latch) begin
                pat_q    <= cfg_pattern;
                len_q    <= len_clamp;
                thresh_q <= cfg_thresh;
            end
            if (cnt_clear)
                match_cnt <= '0;
            else if (take)
                match_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl; expectations follow SEQ_DETECT_OVERLAP_EN.
module tb_seq_detect_ctrl;
    import seq_detect_pkg::*;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 8;
`ifdef SEQ_DETECT_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic               clk, rst;
    logic               cfg_valid, cfg_ready;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               start, stop, x, x_valid;
    logic               z, busy, done;
    logic [CNT_W-1:0]   match_cnt;

    seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int bit_n;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   bits_sent = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic expect_z(input int b, input int c);
        exp_t e;
        e.bit_n = b;
        e.cnt   = c;
        exp_q.push_back(e);
    endtask

    // Every z pulse must match the head of the queue: which bit completed it and the count.
    always begin
        @(posedge clk);
        #1;
        if (z === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL z_unexpected: pulse after bit %0d, want none", bits_sent);
            end else begin
                mon_e = exp_q.pop_front();
                check("z_bit", 32'(bits_sent), 32'(mon_e.bit_n));
                check("z_cnt", 32'(match_cnt), 32'(mon_e.cnt));
            end
        end
    end

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_thresh  = t;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bits_sent = 0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Sends v[n-1] first; gap inserts idle cycles with x toggling but x_valid low.
    task automatic send_bits(input logic [15:0] v, input int n, input int gap);
        logic [15:0] vv;
        vv = v;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            x       = vv[i];
            x_valid = 1'b1;
            bits_sent++;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                x_valid = 1'b0;
                x       = ~x;
            end
        end
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_z", 32'(z), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // 101 over 1,0,1,0,1, then stop+start on a would-be match
        cfg(8'b101, 4'd3, 8'd0);
        do_start();
        expect_z(3, 1);
        if (OVL) expect_z(5, 2);
        send_bits(16'b10101, 5, 0);
        check("t1_cnt", 32'(match_cnt), OVL ? 2 : 1);
        check("t1_state", 32'(dut.state), OVL ? 32'(RUN) : 32'(FILL));
        check("t1_busy", 32'(busy), 1);
        send_bits(16'b0, 1, 0);
        @(negedge clk);
        x = 1'b1; x_valid = 1'b1; stop = 1'b1; start = 1'b1;
        bits_sent++;
        @(negedge clk);
        x_valid = 1'b0; stop = 1'b0; start = 1'b0;
        check("stop_state", 32'(dut.state), 32'(IDLE));
        check("stop_busy", 32'(busy), 0);
        check("stop_done", 32'(done), 0);
        check("stop_cnt_held", 32'(match_cnt), OVL ? 2 : 1);
        check("stop_cfg_ready", 32'(cfg_ready), 1);

        // len 0 behaves as len 1; gaps between bits hold state
        cfg(8'h01, 4'd0, 8'd0);
        do_start();
        check("t2_cnt_cleared", 32'(match_cnt), 0);
        expect_z(1, 1);
        expect_z(3, 2);
        send_bits(16'b101, 3, 2);
        check("t2_cnt", 32'(match_cnt), 2);
        do_stop();

        // threshold 2 ends the run in DONE
        cfg(8'b11, 4'd2, 8'd2);
        do_start();
        expect_z(2, 1);
        expect_z(OVL ? 3 : 4, 2);
        send_bits(16'b1111, 4, 0);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_cnt", 32'(match_cnt), 2);
        send_bits(16'b1, 1, 0);
        check("t3_cnt_done_hold", 32'(match_cnt), 2);
        do_start();
        check("t3_restart_done", 32'(done), 0);
        check("t3_restart_busy", 32'(busy), 1);
        check("t3_restart_cnt", 32'(match_cnt), 0);
        do_stop();

        // len 15 clamps to 8; async reset mid-run
        cfg(8'hA5, 4'd15, 8'd0);
        do_start();
        expect_z(8, 1);
        send_bits(16'h00A5, 8, 1);
        check("t4_cnt", 32'(match_cnt), 1);
        send_bits(16'b101, 3, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_z", 32'(z), 0);
        check("arst_cnt", 32'(match_cnt), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_cfg_ready", 32'(cfg_ready), 1);
        check("arst_pat", 32'(dut.pat_q), 0);
        check("arst_len", 32'(dut.len_q), 1);
        check("arst_thresh", 32'(dut.thresh_q), 0);

        // cfg offered mid-run is ignored
        cfg(8'b11, 4'd2, 8'd0);
        do_start();
        expect_z(2, 1);
        send_bits(16'b11, 2, 0);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd2;
        check("run_cfg_ready", 32'(cfg_ready), 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("run_cfg_pat", 32'(dut.pat_q), 3);
        expect_z(6, 2);
        send_bits(16'b0011, 4, 0);
        check("t5_cnt", 32'(match_cnt), 2);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
